// File: rtl/spm_mem_pkg.sv
// Shared definitions for the scratch-pad memory responder.
//   DataWidth / AddrWidth : word and address widths of the memory
//   CntWidth              : width of the wait-cycle counter
//   state_e               : responder FSM encoding (IDLE, WAIT, RESP)
package spm_mem_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned AddrWidth = 8;
    localparam int unsigned CntWidth  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/spm_mem_responder_if.sv
// Request/response bus between the control unit and the memory responder.
//   req, write, address, data_in : initiator -> responder, sampled on accept
//   data_out                     : read data (Bus_2 path), holds between reads
//   ack, busy, err               : responder status; ack/err pulse in RESP only
// Modports: master (control unit side), slave (responder side).
interface spm_mem_responder_if;
    import spm_mem_pkg::*;

    logic                 req;
    logic                 write;
    logic [AddrWidth-1:0] address;
    logic [DataWidth-1:0] data_in;
    logic [DataWidth-1:0] data_out;
    logic                 ack;
    logic                 busy;
    logic                 err;

    modport master (
        output req, write, address, data_in,
        input  data_out, ack, busy, err
    );

    modport slave (
        input  req, write, address, data_in,
        output data_out, ack, busy, err
    );

endinterface

// File: rtl/spm_mem_array.sv
// 256 x 8 word storage with one synchronous write port and one synchronous
// read port. The read register holds its value until the next read enable,
// so it doubles as the responder's data_out. Storage itself is not reset.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr, rdata : read port, rdata registered
module spm_mem_array
    import spm_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 re,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    localparam int unsigned Depth = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spm_mem_responder.sv
// Scratch-pad memory responder: accepts a level request from the control
// unit, waits WAIT_CYCLES cycles, then commits the write or fetches the read
// and pulses ack for one cycle.
//   clk  : clock, all state changes on rising edge
//   rst  : asynchronous active-high reset
//   bus  : spm_mem_responder_if.slave (req/write/address/data_in in,
//          data_out/ack/busy/err out)
// Parameters: WAIT_CYCLES (0..15), PROT_LIMIT (write-protect bound).
// Build option: define MEM_PROTECT_EN to reject writes below PROT_LIMIT
// (ack with err=1, memory untouched). Without it err is tied low.
module spm_mem_responder
    import spm_mem_pkg::*;
#(
    parameter int unsigned          WAIT_CYCLES = 2,
    parameter logic [AddrWidth-1:0] PROT_LIMIT  = 8'h10
) (
    input logic               clk,
    input logic               rst,
    spm_mem_responder_if.slave bus
);

    localparam bit NoWait = (WAIT_CYCLES == 0);
    localparam logic [CntWidth-1:0] CntInit =
        NoWait ? '0 : CntWidth'(WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic                 wr_q;

    logic                 accept;
    logic                 enter_resp;
    logic [AddrWidth-1:0] op_addr;
    logic [DataWidth-1:0] op_data;
    logic                 op_wr;
    logic                 op_prot;
    logic                 resp_prot;
    logic [DataWidth-1:0] rd_data;

    assign accept     = (state_q == StIdle) && bus.req;
    assign enter_resp = (accept && NoWait) || ((state_q == StWait) && (cnt_q == '0));

    // With zero wait the access happens on the accept edge itself, before the
    // capture registers are loaded, so take the operands straight from the bus.
    assign op_addr = (state_q == StIdle) ? bus.address : addr_q;
    assign op_data = (state_q == StIdle) ? bus.data_in : data_q;
    assign op_wr   = (state_q == StIdle) ? bus.write   : wr_q;

`ifdef MEM_PROTECT_EN
    assign op_prot   = op_wr && (op_addr < PROT_LIMIT);
    assign resp_prot = wr_q && (addr_q < PROT_LIMIT);
`else
    assign op_prot   = 1'b0;
    assign resp_prot = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d = NoWait ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ack      = (state_q == StResp);
        bus.busy     = (state_q == StWait) || (state_q == StResp);
        bus.err      = (state_q == StResp) && resp_prot;
        bus.data_out = rd_data;
    end

    // Wait counter and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q  <= CntInit;
                addr_q <= bus.address;
                data_q <= bus.data_in;
                wr_q   <= bus.write;
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    spm_mem_array u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (enter_resp && op_wr && !op_prot),
        .waddr (op_addr),
        .wdata (op_data),
        .re    (enter_resp && !op_wr),
        .raddr (op_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_spm_mem_responder.sv
// Directed bench for spm_mem_responder: one instance with WAIT_CYCLES=2 and
// one with WAIT_CYCLES=0 sharing clock and reset.
module tb_spm_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spm_mem_responder_if if2 ();
    spm_mem_responder_if if0 ();

    spm_mem_responder #(.WAIT_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    spm_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel0, input logic r, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (sel0) begin
            if0.req = r; if0.write = w; if0.address = a; if0.data_in = d;
        end else begin
            if2.req = r; if2.write = w; if2.address = a; if2.data_in = d;
        end
    endtask

    function automatic logic get_ack(input bit sel0);
        return sel0 ? if0.ack : if2.ack;
    endfunction

    function automatic logic get_busy(input bit sel0);
        return sel0 ? if0.busy : if2.busy;
    endfunction

    // Called just after a rising edge; returns after the edge that samples ack
    // with req already dropped (a following call re-raises it immediately).
    task automatic txn(input bit sel0, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input bit toggle,
                       output logic [7:0] rd, output int lat, output logic ev,
                       output int bcnt, output int acyc);
        drive(sel0, 1'b1, wr, a, d);
        @(posedge clk); #1;
        if (toggle) drive(sel0, 1'b1, wr, ~a, ~d);
        lat = 0; bcnt = 0; rd = '0; ev = 1'b0; acyc = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (get_busy(sel0)) bcnt++;
            if (get_ack(sel0)) begin
                rd   = sel0 ? if0.data_out : if2.data_out;
                ev   = sel0 ? if0.err : if2.err;
                acyc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        drive(sel0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] pre;
        logic       ev;
        int         lat, bc, ac, ac_prev, nack;

        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", if2.data_out, 8'h00);
        check("rst_ack", if2.ack, 1'b0);
        check("rst_busy", if2.busy, 1'b0);
        check("rst_err", if2.err, 1'b0);
        check("rst_data_out0", if0.data_out, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write then read with two wait cycles
        txn(1'b0, 1'b1, 8'h40, 8'hA5, 1'b0, rd, lat, ev, bc, ac);
        check("wr_lat", lat, 3);
        check("wr_busy_cycles", bc, 3);
        check("wr_err", ev, 1'b0);
        check("wr_data_out_held", rd, 8'h00);
        @(negedge clk);
        check("ack_one_cycle", if2.ack, 1'b0);
        check("busy_after", if2.busy, 1'b0);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 8'h40, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("rd_lat", lat, 3);
        check("rd_data", rd, 8'hA5);

        // Zero wait cycles
        txn(1'b1, 1'b1, 8'h30, 8'h5A, 1'b0, rd, lat, ev, bc, ac);
        check("w0_wr_lat", lat, 1);
        txn(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("w0_rd_lat", lat, 1);
        check("w0_rd_busy_cycles", bc, 1);
        check("w0_rd_data", rd, 8'h5A);
        @(negedge clk);
        check("w0_busy_after", if0.busy, 1'b0);
        @(posedge clk); #1;

        // Back-to-back: three writes then three reads, req re-raised at once
        txn(1'b0, 1'b1, 8'h41, 8'h11, 1'b0, rd, lat, ev, bc, ac);
        txn(1'b0, 1'b1, 8'h42, 8'h22, 1'b0, rd, lat, ev, bc, ac);
        txn(1'b0, 1'b1, 8'h43, 8'h33, 1'b0, rd, lat, ev, bc, ac);
        txn(1'b0, 1'b0, 8'h41, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("b2b_rd1", rd, 8'h11);
        ac_prev = ac;
        txn(1'b0, 1'b0, 8'h42, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("b2b_rd2", rd, 8'h22);
        check("b2b_gap1", ac - ac_prev, 4);
        ac_prev = ac;
        txn(1'b0, 1'b0, 8'h43, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("b2b_rd3", rd, 8'h33);
        check("b2b_gap2", ac - ac_prev, 4);

        // Reset during WAIT aborts a write
        txn(1'b0, 1'b1, 8'h20, 8'h77, 1'b0, rd, lat, ev, bc, ac);
        drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h3C);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("abort_ack", if2.ack, 1'b0);
        check("abort_busy", if2.busy, 1'b0);
        check("abort_data_out", if2.data_out, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        nack = 0;
        repeat (4) begin
            @(negedge clk);
            if (if2.ack) nack++;
        end
        check("abort_no_ack", nack, 0);
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("abort_mem_kept", rd, 8'h77);

        // Inputs toggled during WAIT are ignored
        txn(1'b0, 1'b1, 8'h50, 8'hC3, 1'b1, rd, lat, ev, bc, ac);
        txn(1'b0, 1'b0, 8'h50, 8'h00, 1'b1, rd, lat, ev, bc, ac);
        check("stable_rd", rd, 8'hC3);
        check("stable_lat", lat, 3);

        // Write protection below PROT_LIMIT (8'h10)
`ifdef MEM_PROTECT_EN
        txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, pre, lat, ev, bc, ac);
        txn(1'b0, 1'b1, 8'h05, 8'hFF, 1'b0, rd, lat, ev, bc, ac);
        check("prot_ack_lat", lat, 3);
        check("prot_err", ev, 1'b1);
        txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("prot_mem_kept", rd, pre);
        check("prot_rd_err", ev, 1'b0);
`else
        pre = 8'hFF;
        txn(1'b0, 1'b1, 8'h05, 8'hFF, 1'b0, rd, lat, ev, bc, ac);
        check("noprot_err", ev, 1'b0);
        txn(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("noprot_commit", rd, pre);
`endif
        txn(1'b0, 1'b1, 8'h10, 8'hFF, 1'b0, rd, lat, ev, bc, ac);
        check("limit_err", ev, 1'b0);
        txn(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, rd, lat, ev, bc, ac);
        check("limit_commit", rd, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
